// File: rtl/hazard_stall_sequencer_pkg.sv
// Shared opcodes, FSM state encoding and dependency helpers for the stall sequencer.
// Pure declarations; no timing or flow-control behaviour of its own.
package hazard_stall_sequencer_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // rt is a source operand only for R-type, sw and beq; elsewhere it is a destination.
    function automatic logic rt_is_source(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

    function automatic logic depends_on(input logic [4:0] r, input logic [5:0] op,
                                        input logic [4:0] rs, input logic [4:0] rt);
        return (r != 5'd0) && ((r == rs) || (rt_is_source(op) && (r == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_sequencer_hazard_compare.sv
// Combinational hazard classifier: bubble count needed for the instruction in ID.
// Zero latency; no flow control.
module hazard_compare
    import hazard_stall_sequencer_pkg::*;
(
    input  logic [5:0] IFID_op,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic       IDEX_MemRead,
    input  logic       IDEX_RegWrite,
    input  logic [4:0] IDEX_WriteReg,
    input  logic       EXMEM_MemRead,
    input  logic [4:0] EXMEM_WriteReg,
    output logic [1:0] bubbles
);

    logic is_beq;
    logic dep_ex;
    logic dep_mem;
    logic lu, ba, bl, bm;

    assign is_beq  = (IFID_op == OP_BEQ);
    assign dep_ex  = depends_on(IDEX_WriteReg, IFID_op, IFID_Rs, IFID_Rt);
    assign dep_mem = depends_on(EXMEM_WriteReg, IFID_op, IFID_Rs, IFID_Rt);

    assign lu = IDEX_MemRead & dep_ex;
    assign ba = is_beq & IDEX_RegWrite & ~IDEX_MemRead & dep_ex;
    assign bl = is_beq & IDEX_MemRead & dep_ex;
    assign bm = is_beq & EXMEM_MemRead & dep_mem;

    // Branch resolves in ID, so a load feeding it needs a second bubble.
    always_comb begin
        bubbles = 2'd0;
        if (lu | ba | bm)
            bubbles = 2'd1;
        if (bl)
            bubbles = 2'd2;
    end

endmodule

// File: rtl/hazard_stall_sequencer.sv
// Stall sequencer for the 5-stage core: load-use / branch bubbles and data-memory wait freeze.
// Mealy outputs (same cycle); Mem_Ready low freezes the back pipeline up to MEM_TIMEOUT cycles.
module hazard_stall_sequencer
    import hazard_stall_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       IFID_op,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [4:0]       IDEX_WriteReg,
    input  logic             EXMEM_MemRead,
    input  logic             EXMEM_MemAccess,
    input  logic [4:0]       EXMEM_WriteReg,
    input  logic             Mem_Ready,
    input  logic             perf_clear,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             Control_Write,
    output logic             Pipe_Freeze,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int             TW       = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(MEM_TIMEOUT - 1);

    state_t        state, state_nx;
    logic [1:0]    bubbles_left, bubbles_left_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic [1:0]    hazard_n;
    logic          memwait;
    logic          err_set;
    logic          pc_w, ctl_w, frz;

    hazard_compare u_cmp (
        .IFID_op        (IFID_op),
        .IFID_Rs        (IFID_Rs),
        .IFID_Rt        (IFID_Rt),
        .IDEX_MemRead   (IDEX_MemRead),
        .IDEX_RegWrite  (IDEX_RegWrite),
        .IDEX_WriteReg  (IDEX_WriteReg),
        .EXMEM_MemRead  (EXMEM_MemRead),
        .EXMEM_WriteReg (EXMEM_WriteReg),
        .bubbles        (hazard_n)
    );

    assign memwait = EXMEM_MemAccess & ~Mem_Ready;

    always_comb begin
        state_nx        = state;
        bubbles_left_nx = bubbles_left;
        tmo_nx          = tmo;
        err_set         = 1'b0;
        pc_w            = 1'b1;
        ctl_w           = 1'b1;
        frz             = 1'b0;
        case (state)
            ST_RUN: begin
                if (memwait) begin
                    state_nx = ST_MEM_WAIT;
                    tmo_nx   = TW'(1);
                    pc_w     = 1'b0;
                    frz      = 1'b1;
                end else if (hazard_n != 2'd0) begin
                    pc_w  = 1'b0;
                    ctl_w = 1'b0;
                    if (hazard_n == 2'd2) begin
                        bubbles_left_nx = 2'd1;
                        state_nx        = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (memwait) begin
                    state_nx = ST_MEM_WAIT;
                    tmo_nx   = TW'(1);
                    pc_w     = 1'b0;
                    frz      = 1'b1;
                end else begin
                    pc_w  = 1'b0;
                    ctl_w = 1'b0;
                    if (bubbles_left != 2'd0)
                        bubbles_left_nx = bubbles_left - 2'd1;
                    if (bubbles_left <= 2'd1)
                        state_nx = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (Mem_Ready) begin
                    // Freeze drops this cycle; any bubble owed from before the wait is paid now.
                    tmo_nx = '0;
                    if (bubbles_left != 2'd0) begin
                        pc_w            = 1'b0;
                        ctl_w           = 1'b0;
                        bubbles_left_nx = bubbles_left - 2'd1;
                    end
                    state_nx = (bubbles_left > 2'd1) ? ST_STALL : ST_RUN;
                end else if (tmo == TMO_LAST) begin
                    err_set         = 1'b1;
                    pc_w            = 1'b0;
                    frz             = 1'b1;
                    state_nx        = ST_RUN;
                    bubbles_left_nx = 2'd0;
                    tmo_nx          = '0;
                end else begin
                    tmo_nx = tmo + TW'(1);
                    pc_w   = 1'b0;
                    frz    = 1'b1;
                end
            end
            default: state_nx = ST_RUN;
        endcase
    end

    assign PC_Write      = ~rst & pc_w;
    assign IFID_Write    = ~rst & pc_w;
    assign Control_Write = ~rst & ctl_w;
    assign Pipe_Freeze   = rst | frz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            bubbles_left <= 2'd0;
            tmo          <= '0;
            mem_error    <= 1'b0;
            stall_count  <= '0;
        end else begin
            state        <= state_nx;
            bubbles_left <= bubbles_left_nx;
            tmo          <= tmo_nx;
            if (err_set)
                mem_error <= 1'b1;
            if (perf_clear)
                stall_count <= '0;
            else if (!pc_w && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_sequencer.sv
// Directed bench for hazard_stall_sequencer: vector table for single-cycle hazards plus
// hand-written multi-cycle sequences (STALL, MEM_WAIT, timeout, reset, counter saturation).
module tb_hazard_stall_sequencer;

    localparam int CNT_W = 4;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW_C = 6'b100011;
    localparam logic [5:0] OP_SW_C = 6'b101011;
    localparam logic [5:0] OP_BQ   = 6'b000100;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       IFID_op;
    logic [4:0]       IFID_Rs, IFID_Rt;
    logic             IDEX_MemRead, IDEX_RegWrite;
    logic [4:0]       IDEX_WriteReg;
    logic             EXMEM_MemRead, EXMEM_MemAccess;
    logic [4:0]       EXMEM_WriteReg;
    logic             Mem_Ready, perf_clear;
    logic             PC_Write, IFID_Write, Control_Write, Pipe_Freeze, mem_error;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_sequencer #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .IFID_op(IFID_op), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_WriteReg(IDEX_WriteReg),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemAccess(EXMEM_MemAccess),
        .EXMEM_WriteReg(EXMEM_WriteReg), .Mem_Ready(Mem_Ready), .perf_clear(perf_clear),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .Control_Write(Control_Write),
        .Pipe_Freeze(Pipe_Freeze), .mem_error(mem_error), .stall_count(stall_count)
    );

    typedef struct {
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic       idex_mr, idex_rw;
        logic [4:0] idex_wr;
        logic       exmem_mr;
        logic [4:0] exmem_wr;
        logic [3:0] exp;   // {PC_Write, IFID_Write, Control_Write, Pipe_Freeze}
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic imr, input logic irw, input logic [4:0] iwr,
                                input logic emr, input logic [4:0] ewr, input logic [3:0] exp);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.idex_mr = imr; v.idex_rw = irw; v.idex_wr = iwr;
        v.exmem_mr = emr; v.exmem_wr = ewr; v.exp = exp;
        return v;
    endfunction

    task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic imr, input logic irw, input logic [4:0] iwr,
                          input logic emr, input logic eacc, input logic [4:0] ewr,
                          input logic rdy);
        IFID_op = op; IFID_Rs = rs; IFID_Rt = rt;
        IDEX_MemRead = imr; IDEX_RegWrite = irw; IDEX_WriteReg = iwr;
        EXMEM_MemRead = emr; EXMEM_MemAccess = eacc; EXMEM_WriteReg = ewr;
        Mem_Ready = rdy;
    endtask

    task automatic idle();
        set_in(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {PC_Write, IFID_Write, Control_Write, Pipe_Freeze};
    endfunction

    // Inputs change at posedge+1, outputs are sampled mid-cycle, state commits at the next posedge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_perf();
        idle();
        perf_clear = 1'b1;
        next();
        perf_clear = 1'b0;
    endtask

    initial begin
        int model_cnt;

        vecs[0]  = mk(OP_R,    5'd1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 4'b1110);
        vecs[1]  = mk(OP_R,    5'd2, 5'd3, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 4'b0000);
        vecs[2]  = mk(OP_R,    5'd1, 5'd4, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 4'b0000);
        vecs[3]  = mk(OP_ADDI, 5'd1, 5'd4, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 4'b1110);
        vecs[4]  = mk(OP_R,    5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 4'b1110);
        vecs[5]  = mk(OP_BQ,   5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 4'b0000);
        vecs[6]  = mk(OP_BQ,   5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 4'b1110);
        vecs[7]  = mk(OP_R,    5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 4'b1110);
        vecs[8]  = mk(OP_BQ,   5'd9, 5'd1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 4'b0000);
        vecs[9]  = mk(OP_R,    5'd9, 5'd1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 4'b1110);
        vecs[10] = mk(OP_SW_C, 5'd1, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 4'b0000);
        vecs[11] = mk(OP_LW_C, 5'd1, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 4'b1110);
        vecs[12] = mk(OP_BQ,   5'd3, 5'd9, 1'b0, 1'b1, 5'd3, 1'b1, 5'd9, 4'b0000);
        vecs[13] = mk(OP_BQ,   5'd1, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 5'd2, 4'b0000);
        vecs[14] = mk(OP_BQ,   5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd2, 4'b1110);

        rst = 1'b1;
        perf_clear = 1'b0;
        idle();
        #12;
        chk("reset_outs", 32'(outs()), 32'b0001);
        chk("reset_cnt", 32'(stall_count), 0);
        chk("reset_err", 32'(mem_error), 0);
        next();
        rst = 1'b0;
        #4 chk("run_idle", 32'(outs()), 32'b1110);
        next();

        model_cnt = 0;
        foreach (vecs[i]) begin
            set_in(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].idex_mr, vecs[i].idex_rw,
                   vecs[i].idex_wr, vecs[i].exmem_mr, 1'b0, vecs[i].exmem_wr, 1'b1);
            #4 chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
            if (vecs[i].exp[3] == 1'b0 && model_cnt < 15)
                model_cnt++;
            next();
        end
        chk("table_cnt", 32'(stall_count), 32'(model_cnt));

        // lw $5 in EX, beq on $5: two bubbles, second from STALL, then RUN.
        clear_perf();
        set_in(OP_BQ, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1);
        #4 chk("bl_c1", 32'(outs()), 32'b0000);
        next();
        #4 chk("bl_c2", 32'(outs()), 32'b0000);
        next();
        idle();
        #4 chk("bl_c3", 32'(outs()), 32'b1110);
        next();
        chk("bl_cnt", 32'(stall_count), 2);

        // Memory busy three cycles, released on the fourth.
        clear_perf();
        set_in(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #4 chk($sformatf("mw_frz%0d", k), 32'(outs()), 32'b0011);
            next();
        end
        Mem_Ready = 1'b1;
        #4 chk("mw_rel", 32'(outs()), 32'b1110);
        next();
        idle();
        #4 chk("mw_after", 32'(outs()), 32'b1110);
        next();
        chk("mw_cnt", 32'(stall_count), 3);
        chk("mw_err", 32'(mem_error), 0);

        // MEM_WAIT entered from STALL: owed bubble is paid on release.
        clear_perf();
        set_in(OP_BQ, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1);
        #4 chk("ms_c1", 32'(outs()), 32'b0000);
        next();
        set_in(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        #4 chk("ms_frz_entry", 32'(outs()), 32'b0011);
        next();
        #4 chk("ms_frz_wait", 32'(outs()), 32'b0011);
        next();
        Mem_Ready = 1'b1;
        #4 chk("ms_rel_bubble", 32'(outs()), 32'b0000);
        next();
        idle();
        #4 chk("ms_run", 32'(outs()), 32'b1110);
        next();
        chk("ms_cnt", 32'(stall_count), 4);

        // perf_clear wins over a same-cycle increment.
        set_in(OP_R, 5'd2, 5'd3, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
        perf_clear = 1'b1;
        #4 chk("pc_bubble", 32'(outs()), 32'b0000);
        next();
        perf_clear = 1'b0;
        chk("pc_cnt", 32'(stall_count), 0);

        // Mem_Ready never rises: 16 freeze cycles, sticky error, counter saturates at 15.
        set_in(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            #4 chk($sformatf("tmo_frz%0d", k), 32'(outs()), 32'b0011);
            if (k == 15)
                chk("tmo_err_before", 32'(mem_error), 0);
            next();
        end
        idle();
        #4 chk("tmo_run", 32'(outs()), 32'b1110);
        chk("tmo_err", 32'(mem_error), 1);
        chk("tmo_cnt_sat", 32'(stall_count), 15);
        next();
        clear_perf();
        chk("tmo_err_sticky", 32'(mem_error), 1);

        // Reset in the middle of a STALL.
        set_in(OP_BQ, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1);
        #4 chk("rs_c1", 32'(outs()), 32'b0000);
        next();
        rst = 1'b1;
        #4 chk("rs_outs", 32'(outs()), 32'b0001);
        chk("rs_err", 32'(mem_error), 0);
        chk("rs_cnt", 32'(stall_count), 0);
        next();
        rst = 1'b0;
        idle();
        #4 chk("rs_run", 32'(outs()), 32'b1110);
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
